// File: rtl/sampler_pkg.sv
// Shared defaults and counter sizing for the oversampling bit voter.
package sampler_pkg;

  localparam int NUM_SAMPLES_DEF = 3;
  localparam int PRESCALE_W_DEF  = 6;
  localparam int CNT_W_DEF       = $clog2(NUM_SAMPLES_DEF + 1);

  // Counter must reach NUM_SAMPLES itself, hence n+1 codes.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/maj_vote.sv
// Combinational popcount majority/unanimity over the captured oversamples.
module maj_vote
  import sampler_pkg::*;
#(
  parameter int NUM_SAMPLES = NUM_SAMPLES_DEF
) (
  input  logic [NUM_SAMPLES-1:0] samples_i,
  output logic                   majority_o,
  output logic                   unanimous_o
);

  localparam int CNT_W = cnt_width(NUM_SAMPLES);

  logic [CNT_W-1:0] ones;

  always_comb begin
    ones = '0;
    for (int k = 0; k < NUM_SAMPLES; k++) begin
      ones = ones + CNT_W'(samples_i[k]);
    end
  end

  assign majority_o  = (ones > CNT_W'(NUM_SAMPLES / 2));
  assign unanimous_o = (ones == '0) || (ones == CNT_W'(NUM_SAMPLES));

endmodule

// File: rtl/vote_sampler.sv
// UART-style oversampling bit sampler: captures NUM_SAMPLES samples around mid-bit
// and majority-votes them at the bit end. Optional macro VOTE_SAMPLER_NOISE_FLAG_EN.
module vote_sampler
  import sampler_pkg::*;
#(
  parameter int NUM_SAMPLES = NUM_SAMPLES_DEF,
  parameter int PRESCALE_W  = PRESCALE_W_DEF
) (
  input  logic                  clck,
  input  logic                  rst,
  input  logic                  s_data,
  input  logic                  dat_samp_en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  output logic                  sampled_bit,
  output logic                  sampled_valid,
  output logic                  noise_err
);

  localparam int CNT_W = cnt_width(NUM_SAMPLES);
  localparam int EW    = PRESCALE_W + 1;

  generate
    if (NUM_SAMPLES != 3 && NUM_SAMPLES != 5 && NUM_SAMPLES != 7) begin : g_bad_num_samples
      $error("vote_sampler: NUM_SAMPLES must be 3, 5 or 7");
    end
  endgenerate

  logic [NUM_SAMPLES-1:0] samp_q, samp_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   bit_q, bit_d;
  logic                   vld_q, vld_d;

  logic [EW-1:0] ps_x, edge_x, base_x;
  logic          legal, in_range, vote_pt;
  logic          maj;

  // One extra bit keeps the window arithmetic free of wrap-around.
  assign ps_x     = {1'b0, prescale};
  assign edge_x   = {1'b0, edge_cnt};
  assign base_x   = (ps_x >> 1) - EW'(NUM_SAMPLES - 1);
  assign legal    = (ps_x >= EW'(2 * NUM_SAMPLES));
  assign in_range = (edge_x < ps_x);
  assign vote_pt  = (edge_x == ps_x - EW'(1));

  always_comb begin
    samp_d = samp_q;
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    vld_d  = 1'b0;
    if (!dat_samp_en || !legal) begin
      cnt_d = '0;
    end else if (in_range) begin
      if (vote_pt) begin
        cnt_d = '0;
        if (cnt_q == CNT_W'(NUM_SAMPLES)) begin
          vld_d = 1'b1;
          bit_d = maj;
        end
      end else begin
        for (int k = 0; k < NUM_SAMPLES; k++) begin
          if (edge_x == base_x + EW'(k)) begin
            samp_d[k] = s_data;
            if (cnt_q != CNT_W'(NUM_SAMPLES)) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clck) begin
    if (rst) begin
      samp_q <= '1;
      cnt_q  <= '0;
      bit_q  <= 1'b1;
      vld_q  <= 1'b0;
    end else begin
      samp_q <= samp_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      vld_q  <= vld_d;
    end
  end

  assign sampled_bit   = bit_q;
  assign sampled_valid = vld_q;

`ifdef VOTE_SAMPLER_NOISE_FLAG_EN
  logic unan;
  logic noise_q, noise_d;

  maj_vote #(.NUM_SAMPLES(NUM_SAMPLES)) u_maj_vote (
    .samples_i   (samp_q),
    .majority_o  (maj),
    .unanimous_o (unan)
  );

  // Flag refreshes only on a vote that actually fires.
  assign noise_d = vld_d ? ~unan : noise_q;

  always_ff @(posedge clck) begin
    if (rst) begin
      noise_q <= 1'b0;
    end else begin
      noise_q <= noise_d;
    end
  end

  assign noise_err = noise_q;
`else
  logic unan_unused;

  maj_vote #(.NUM_SAMPLES(NUM_SAMPLES)) u_maj_vote (
    .samples_i   (samp_q),
    .majority_o  (maj),
    .unanimous_o (unan_unused)
  );

  assign noise_err = 1'b0;
`endif

endmodule

// File: tb/tb_vote_sampler.sv
// Directed scoreboard bench for vote_sampler with one N=3 and one N=5 instance.
module tb_vote_sampler;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_data [2];
  logic       en     [2];
  logic [5:0] ps     [2];
  logic [5:0] ec     [2];
  logic       bit_o  [2];
  logic       vld_o  [2];
  logic       nerr_o [2];

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic b;
    logic n;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  logic last_b [2];
  logic last_n [2];

`ifdef VOTE_SAMPLER_NOISE_FLAG_EN
  localparam bit FLAG_EN = 1'b1;
`else
  localparam bit FLAG_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  vote_sampler #(.NUM_SAMPLES(3), .PRESCALE_W(6)) dut3 (
    .clck(clk), .rst(rst), .s_data(s_data[0]), .dat_samp_en(en[0]),
    .prescale(ps[0]), .edge_cnt(ec[0]), .sampled_bit(bit_o[0]),
    .sampled_valid(vld_o[0]), .noise_err(nerr_o[0])
  );

  vote_sampler #(.NUM_SAMPLES(5), .PRESCALE_W(6)) dut5 (
    .clck(clk), .rst(rst), .s_data(s_data[1]), .dat_samp_en(en[1]),
    .prescale(ps[1]), .edge_cnt(ec[1]), .sampled_bit(bit_o[1]),
    .sampled_valid(vld_o[1]), .noise_err(nerr_o[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic int sb_size(input int w);
    return (w == 0) ? sb0.size() : sb1.size();
  endfunction

  // Drives one bit period on instance w; pat[k] is the value presented at window slot k.
  task automatic drive_bit(input int w, input int prs, input logic [6:0] pat,
                           input bit exp_vote, input int drop_at, input int rst_at);
    int   n;
    int   base;
    int   ones;
    exp_t item;
    exp_t got;
    n    = (w == 0) ? 3 : 5;
    base = prs / 2 - (n - 1);
    ones = 0;
    for (int k = 0; k < n; k++) ones += int'(pat[k]);
    item.b = (ones > n / 2);
    item.n = FLAG_EN && (ones != 0) && (ones != n);
    if (exp_vote) begin
      if (w == 0) sb0.push_back(item);
      else        sb1.push_back(item);
    end
    for (int e = 0; e < prs; e++) begin
      ps[w]     = 6'(prs);
      ec[w]     = 6'(e);
      en[w]     = (e != drop_at);
      rst       = (e == rst_at);
      s_data[w] = (e >= base && e < base + n) ? pat[e - base] : 1'($urandom);
      @(posedge clk);
      #1;
      if (e == rst_at) begin
        check("rst_mid_bit", bit_o[w], 1);
        check("rst_mid_vld", vld_o[w], 0);
        check("rst_mid_noise", nerr_o[w], 0);
        last_b[0] = 1'b1; last_b[1] = 1'b1;
        last_n[0] = 1'b0; last_n[1] = 1'b0;
      end
      check($sformatf("valid_w%0d_e%0d", w, e), vld_o[w], (exp_vote && e == prs - 1));
      if (vld_o[w] === 1'b1) begin
        check("sb_pending", sb_size(w), 1);
        if (sb_size(w) > 0) begin
          got = (w == 0) ? sb0.pop_front() : sb1.pop_front();
          check($sformatf("bit_w%0d", w), bit_o[w], got.b);
          check($sformatf("noise_w%0d", w), nerr_o[w], got.n);
          last_b[w] = got.b;
          last_n[w] = got.n;
        end
      end
    end
    rst   = 1'b0;
    en[w] = 1'b0;
    check("sb_drain", sb_size(w), 0);
    check($sformatf("hold_bit_w%0d", w), bit_o[w], last_b[w]);
    check($sformatf("hold_noise_w%0d", w), nerr_o[w], last_n[w]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_data[i] = 1'b0; en[i] = 1'b1; ps[i] = 6'd8; ec[i] = 6'd7;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("reset_bit", bit_o[i], 1);
      check("reset_vld", vld_o[i], 0);
      check("reset_noise", nerr_o[i], 0);
      last_b[i] = 1'b1;
      last_n[i] = 1'b0;
      en[i] = 1'b0;
    end
    rst = 1'b0;

    // N=3, prescale 8: window at edges 2,3,4.
    drive_bit(0, 8, 7'b0000101, 1'b1, -1, -1);
    drive_bit(0, 8, 7'b0000010, 1'b1, -1, -1);
    drive_bit(0, 8, 7'b0000111, 1'b1, -1, -1);
    drive_bit(0, 8, 7'b0000000, 1'b0, 3, -1);
    drive_bit(0, 8, 7'b0000000, 1'b1, -1, -1);
    drive_bit(0, 8, 7'b0000000, 1'b0, -1, 4);
    drive_bit(0, 8, 7'b0000110, 1'b1, -1, -1);

    // Out-of-range edge indices must do nothing.
    for (int e = 8; e < 12; e++) begin
      ps[0] = 6'd8; ec[0] = 6'(e); en[0] = 1'b1; s_data[0] = 1'b0;
      @(posedge clk);
      #1;
      check("oor_vld", vld_o[0], 0);
      check("oor_bit", bit_o[0], last_b[0]);
    end
    en[0] = 1'b0;
    drive_bit(0, 8, 7'b0000001, 1'b1, -1, -1);

    // N=5, prescale 16: window at edges 4..8.
    repeat (4) drive_bit(1, 16, 7'b0000000, 1'b1, -1, -1);
    drive_bit(1, 16, 7'b0001011, 1'b1, -1, -1);
    drive_bit(1, 16, 7'b0010100, 1'b1, -1, -1);

    // N=5, prescale 8 is illegal: nothing may be voted.
    repeat (3) drive_bit(1, 8, 7'b0011111, 1'b0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vote_sampler.md
VOTE_SAMPLER -- requirements
Module: vote_sampler

Interface
REQ-001 Parameter NUM_SAMPLES, default 3, meaning odd count of oversamples voted per bit; legal values 3, 5, 7.
REQ-002 Parameter PRESCALE_W, default 6, meaning width of prescale and edge_cnt.
REQ-003 clck  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 s_data  input  1  serial line, already synchronised to clck.
REQ-006 dat_samp_en  input  1  capture/vote enable from the RX FSM.
REQ-007 prescale  input  PRESCALE_W  oversampling ratio, in edge counts per bit.
REQ-008 edge_cnt  input  PRESCALE_W  current edge index within the bit, 0..prescale-1.
REQ-009 sampled_bit  output  1  majority-voted bit value.
REQ-010 sampled_valid  output  1  one-cycle pulse; sampled_bit updated this cycle.
REQ-011 noise_err  output  1  samples of the last voted bit were not unanimous.

Function
REQ-012 Capture window: sample k (k=0..NUM_SAMPLES-1) SHALL be taken from s_data when edge_cnt == prescale/2 - (NUM_SAMPLES-1) + k; prescale/2 is floor division.
REQ-013 Each capture SHALL write only its own sample register; all others hold.
REQ-014 A capture counter, width clog2(NUM_SAMPLES+1), SHALL count captures in the current bit and SHALL saturate at NUM_SAMPLES.
REQ-015 Vote point: at edge_cnt == prescale-1 with counter == NUM_SAMPLES, sampled_bit SHALL load 1 when the popcount of the samples exceeds NUM_SAMPLES/2, else 0, and sampled_valid SHALL pulse high for exactly that cycle.
REQ-016 At the vote point the capture counter SHALL clear to 0; sample registers hold.
REQ-017 At a vote point with counter < NUM_SAMPLES: no sampled_valid pulse; sampled_bit and noise_err hold; counter clears.
REQ-018 Latency: sampled_bit and sampled_valid SHALL be registered and visible in the cycle after the edge_cnt == prescale-1 clock edge.
REQ-019 When dat_samp_en is low: no capture, no vote, and the counter clears; sampled_bit and noise_err hold; sampled_valid stays 0.
REQ-020 Legal prescale SHALL be >= 2*NUM_SAMPLES; for an illegal prescale the block SHALL not capture, not vote, and hold all outputs (sampled_valid 0).
REQ-021 prescale change mid-bit: the new value SHALL take effect immediately for window comparisons; any incomplete bit SHALL be handled per REQ-017.
REQ-022 edge_cnt values >= prescale SHALL cause no action.

Reset
REQ-023 With rst high at a clock edge: all sample registers 1, counter 0, sampled_bit 1, sampled_valid 0, noise_err 0.
REQ-024 Reset SHALL dominate dat_samp_en, capture and vote in the same cycle, including mid-bit; the aborted bit SHALL produce no pulse.

Configuration
REQ-025 Macro VOTE_SAMPLER_NOISE_FLAG_EN: when defined, noise_err SHALL load at each valid vote point (1 when popcount is neither 0 nor NUM_SAMPLES, else 0) and hold between votes.
REQ-026 When VOTE_SAMPLER_NOISE_FLAG_EN is undefined, the noise_err port SHALL remain present, tied to 0, with no flag logic synthesised.

Structure
REQ-027 Package sampler_pkg SHALL hold the default NUM_SAMPLES, the default PRESCALE_W, and a constant giving the counter width.
REQ-028 Sub-module maj_vote (combinational, NUM_SAMPLES-wide input; outputs majority and unanimous) SHALL implement the popcount threshold; vote_sampler SHALL hold all state.
REQ-029 The block SHALL elaborate with an error for an even NUM_SAMPLES or a value outside 3..7.

Verification
REQ-030 N=3, prescale=8, samples 1,0,1 at edge_cnt 2,3,4 -> at edge 7, sampled_bit=1, sampled_valid one cycle, noise_err=1 (macro on).
REQ-031 N=5, prescale=16, s_data=0 throughout edges 4..8 -> sampled_bit=0, noise_err=0, one valid pulse per bit over 4 consecutive bits.
REQ-032 N=3, prescale=8, dat_samp_en dropped at edge 3, then restored -> no valid pulse for that bit; the next full bit votes normally.
REQ-033 rst asserted at edge 4 of a bit -> next cycle sampled_bit=1, sampled_valid=0, and no pulse at edge 7.
REQ-034 N=5, prescale=8 (illegal) -> no sampled_valid over 3 bit periods, outputs hold.
REQ-035 Macro off, noisy samples 0,1,0 -> sampled_bit=0 and noise_err remains 0.
